brd_pwm: RTL and testbench
==========================

BRD_PWM -- requirements
Module: brd_pwm

Interface
REQ-001 Parameter: WIDTH, default 32, width of the control word and the status word; SHALL be at least 27.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ctrl_in  input  WIDTH  board control word, driven by the board control register output.
- Field [7:0] duty.
- Field [15:8] presc: tick every presc+1 clocks.
- Field [23:16] top: period length is top+1 ticks.
- Field [24] en.
- Field [25] inv.
- Fields [WIDTH-1:26] ignored.
REQ-005 Port: pwm_out  output  1  registered PWM signal.
REQ-006 Port: period_tick  output  1  registered one-cycle pulse at each period wrap.
REQ-007 Port: status  output  WIDTH  readback word for the bus mux.
- [7:0] cnt.
- [15:8] active duty.
- [23:16] active top.
- [24] running.
- Remaining bits 0.

Function
REQ-008 The block SHALL hold active shadow copies of duty, presc, top and inv, named duty_a, presc_a, top_a and inv_a.
REQ-009 The block SHALL hold an 8-bit prescaler counter pc, an 8-bit period counter cnt and a running flag.
REQ-010 While ctrl_in[24]=0, the following SHALL happen every cycle:
- running=0.
- pc=0 and cnt=0.
- Shadows reload from ctrl_in.
- pwm_out=ctrl_in[25] (idle level).
- period_tick=0.
REQ-011 On the first cycle ctrl_in[24]=1 is sampled, running SHALL become 1 and counting SHALL start from pc=0, cnt=0, using the shadows loaded on the previous cycle.
REQ-012 While running, tick SHALL be defined as (pc==presc_a).
- On tick: pc<=0.
- Otherwise: pc<=pc+1.
REQ-013 On tick with cnt==top_a, the following SHALL happen:
- cnt<=0.
- All four shadows reload from the current ctrl_in.
- period_tick<=1 for exactly one cycle.
REQ-014 On tick with cnt!=top_a, cnt SHALL increment by 1 and the shadows SHALL be unchanged.
REQ-015 ctrl_in changes to duty, presc, top or inv while running SHALL take effect only at the next period wrap (glitch-free update).
REQ-016 While running, pwm_out SHALL register ((cnt<duty_a) XOR inv_a).
- The compare is 8-bit unsigned.
- Latency is 1 cycle from the cnt value.
REQ-017 Boundary cases SHALL behave as follows:
- duty_a=0: output is constantly inv_a.
- duty_a>top_a: output is constantly !inv_a (100%).
- top_a=0: every tick is a wrap.
- presc_a=0: a tick on every clock.
REQ-018 The period SHALL be exactly (presc_a+1)*(top_a+1) clocks.
REQ-019 High time (inv_a=0, duty_a<=top_a) SHALL be exactly (presc_a+1)*duty_a clocks per period.
REQ-020 If ctrl_in[24] deasserts mid-period, the following SHALL happen on the next clock:
- Counters clear.
- pwm_out goes to the idle level.
- No period_tick is issued.
REQ-021 If a reset edge coincides with a wrap, reset SHALL win; no period_tick is issued.
REQ-022 status SHALL be combinational from internal registers, with no added latency.

Reset
REQ-023 While reset=1, all of the following SHALL be 0, independent of clk:
- pwm_out, period_tick, running.
- pc, cnt.
- All shadow registers.
REQ-024 The same zero values SHALL hold as initial values at power-up, before any reset.
REQ-025 After reset deasserts, the block SHALL behave as though disabled until the first cycle ctrl_in[24]=1 is sampled.

Verification
REQ-026 Directed scenario, basic waveform:
- Stimulus: ctrl_in = en=1, presc=0, top=9, duty=3, inv=0.
- Required response: pwm_out high 3 / low 7 clocks, repeating; period_tick every 10 clocks.
REQ-027 Directed scenario, prescaler:
- Stimulus: presc=3, top=4, duty=2.
- Required response: period 20 clocks; high 8 clocks; status[7:0] steps every 4 clocks.
REQ-028 Directed scenario, 0% / 100% / inversion:
- Stimulus: duty=0, then duty=255 with top=9, then inv=1, duty=3.
- Required response: constantly 0, then constantly 1, then low 3 / high 7 clocks.
REQ-029 Directed scenario, mid-period update:
- Stimulus: change duty 3->6 at cnt=1.
- Required response: current period still high 3; next period high 6; status[15:8] changes only at the wrap.
REQ-030 Directed scenario, disable and reset mid-operation:
- Stimulus: drop en at cnt=5 with inv=1, then re-enable; separately pulse reset asynchronously at cnt=5.
- Required response on disable: pwm_out=1 on the next clock and cnt=0; re-enable starts a fresh period.
- Required response on reset: all outputs 0 immediately; no period_tick.
REQ-031 Directed scenario, minimum period:
- Stimulus: top=0, presc=0, duty=1.
- Required response: pwm_out constantly 1; period_tick high every cycle.

Source files
------------

// File: rtl/brd_pwm_if.sv
// Control/readback bundle for the board PWM: control word in, waveform, wrap pulse and status out.
interface brd_pwm_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ctrl_in;
  logic             pwm_out;
  logic             period_tick;
  logic [WIDTH-1:0] status;

  modport master (output ctrl_in, input pwm_out, period_tick, status);
  modport slave  (input ctrl_in, output pwm_out, period_tick, status);
endinterface

// File: rtl/brd_pwm.sv
// Prescaled PWM with shadowed settings that reload only at period wrap (glitch-free updates).
// pwm_out/period_tick are registered (1 cycle after the counter value); status is combinational; no backpressure.
module brd_pwm #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  brd_pwm_if.slave bus
);

  logic [7:0] duty_a  = '0;
  logic [7:0] presc_a = '0;
  logic [7:0] top_a   = '0;
  logic       inv_a   = 1'b0;
  logic [7:0] pc      = '0;
  logic [7:0] cnt     = '0;
  logic       running = 1'b0;
  logic       pwm     = 1'b0;
  logic       wrap_q  = 1'b0;

  logic [7:0] ctrl_duty;
  logic [7:0] ctrl_presc;
  logic [7:0] ctrl_top;
  logic       ctrl_en;
  logic       ctrl_inv;
  logic       tick;
  logic       wrap;
  logic       unused_ctrl;

  assign ctrl_duty   = bus.ctrl_in[7:0];
  assign ctrl_presc  = bus.ctrl_in[15:8];
  assign ctrl_top    = bus.ctrl_in[23:16];
  assign ctrl_en     = bus.ctrl_in[24];
  assign ctrl_inv    = bus.ctrl_in[25];
  assign unused_ctrl = ^bus.ctrl_in[WIDTH-1:26];

  assign tick = (pc == presc_a);
  assign wrap = tick && (cnt == top_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_a  <= '0;
      presc_a <= '0;
      top_a   <= '0;
      inv_a   <= 1'b0;
      pc      <= '0;
      cnt     <= '0;
      running <= 1'b0;
      pwm     <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!ctrl_en) begin
      // Disabled: hold counters at zero and track the control word so enabling starts clean.
      duty_a  <= ctrl_duty;
      presc_a <= ctrl_presc;
      top_a   <= ctrl_top;
      inv_a   <= ctrl_inv;
      pc      <= '0;
      cnt     <= '0;
      running <= 1'b0;
      pwm     <= ctrl_inv;
      wrap_q  <= 1'b0;
    end else begin
      running <= 1'b1;
      pwm     <= (cnt < duty_a) ^ inv_a;
      wrap_q  <= wrap;
      if (tick) begin
        pc <= '0;
        if (wrap) begin
          cnt     <= '0;
          duty_a  <= ctrl_duty;
          presc_a <= ctrl_presc;
          top_a   <= ctrl_top;
          inv_a   <= ctrl_inv;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        pc <= pc + 8'd1;
      end
    end
  end

  assign bus.pwm_out     = pwm;
  assign bus.period_tick = wrap_q;
  assign bus.status      = {{(WIDTH-25){1'b0}}, running, top_a, duty_a, cnt};

endmodule

// File: tb/tb_brd_pwm.sv
// Randomized and directed checks of brd_pwm against a period/phase arithmetic model.
module tb_brd_pwm;

  logic clk = 1'b0;
  logic reset;
  brd_pwm_if #(.WIDTH(32)) bus ();

  brd_pwm #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: elapsed clocks within the current period plus the settings latched at its start.
  int m_phase, m_presc, m_top, m_duty, m_inv, m_run, m_pwm, m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit en, input bit inv, input int top, input int presc, input int duty);
    logic [31:0] c;
    c = '0;
    c[7:0]   = 8'(duty);
    c[15:8]  = 8'(presc);
    c[23:16] = 8'(top);
    c[24]    = en;
    c[25]    = inv;
    return c;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_presc = 0; m_top = 0; m_duty = 0; m_inv = 0;
    m_run = 0; m_pwm = 0; m_tick = 0;
  endtask

  task automatic latch(input logic [31:0] c);
    m_duty  = int'(c[7:0]);
    m_presc = int'(c[15:8]);
    m_top   = int'(c[23:16]);
    m_inv   = int'(c[25]);
  endtask

  task automatic model_edge(input logic [31:0] c);
    int period;
    if (!c[24]) begin
      m_run = 0; m_phase = 0; m_tick = 0;
      m_pwm = int'(c[25]);
      latch(c);
    end else begin
      period = (m_presc + 1) * (m_top + 1);
      m_pwm  = int'((m_phase / (m_presc + 1)) < m_duty) ^ m_inv;
      m_tick = int'(m_phase == period - 1);
      m_run  = 1;
      m_phase++;
      if (m_phase == period) begin
        m_phase = 0;
        latch(c);
      end
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[7:0]   = 8'(m_phase / (m_presc + 1));
    s[15:8]  = 8'(m_duty);
    s[23:16] = 8'(m_top);
    s[24]    = m_run[0];
    return s;
  endfunction

  task automatic cyc();
    logic [31:0] c;
    c = bus.ctrl_in;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(c);
    #1;
    check("pwm", 32'(bus.pwm_out), 32'(m_pwm));
    check("tick", 32'(bus.period_tick), 32'(m_tick));
    check("status", bus.status, exp_status());
  endtask

  task automatic run(input int n, output int hi, output int tk);
    hi = 0;
    tk = 0;
    repeat (n) begin
      cyc();
      hi += int'(bus.pwm_out);
      tk += int'(bus.period_tick);
    end
  endtask

  task automatic restart(input logic [31:0] cfg);
    bus.ctrl_in = cfg & ~32'h0100_0000;
    cyc();
    bus.ctrl_in = cfg;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("rst_tick", 32'(bus.period_tick), 32'd0);
    check("rst_status", bus.status, 32'd0);
    model_reset();
    cyc();
    reset = 1'b0;
  endtask

  task automatic reach_cnt5();
    for (int i = 0; i < 40 && bus.status[7:0] != 8'd5; i++) cyc();
    check("reach_cnt5", 32'(bus.status[7:0]), 32'd5);
  endtask

  initial begin
    int hi, tk, h1;
    logic [31:0] c;
    reset = 1'b0;
    bus.ctrl_in = '0;
    model_reset();
    #1;
    check("pwrup_pwm", 32'(bus.pwm_out), 32'd0);
    check("pwrup_status", bus.status, 32'd0);
    reset = 1'b1;
    #1;
    check("rst0_status", bus.status, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    run(3, hi, tk);

    // Basic waveform: 3 high / 7 low, tick every 10
    restart(mk(1, 0, 9, 0, 3));
    run(30, hi, tk);
    check("basic_hi", 32'(hi), 32'd9);
    check("basic_tk", 32'(tk), 32'd3);

    // Prescaler: period 20, high 8, cnt steps every 4
    restart(mk(1, 0, 4, 3, 2));
    run(4, hi, tk);
    check("presc_step1", 32'(bus.status[7:0]), 32'd1);
    run(4, hi, tk);
    check("presc_step2", 32'(bus.status[7:0]), 32'd2);
    run(40, hi, tk);
    check("presc_hi", 32'(hi), 32'd16);
    check("presc_tk", 32'(tk), 32'd2);

    // 0%, 100%, inverted
    restart(mk(1, 0, 9, 0, 0));
    run(20, hi, tk);
    check("duty0_hi", 32'(hi), 32'd0);
    restart(mk(1, 0, 9, 0, 255));
    run(20, hi, tk);
    check("duty255_hi", 32'(hi), 32'd20);
    restart(mk(1, 1, 9, 0, 3));
    run(30, hi, tk);
    check("inv_hi", 32'(hi), 32'd21);

    // Mid-period duty update takes effect at the wrap only
    restart(mk(1, 0, 9, 0, 3));
    run(1, h1, tk);
    bus.ctrl_in = mk(1, 0, 9, 0, 6);
    run(4, hi, tk);
    h1 += hi;
    check("upd_duty_hold", 32'(bus.status[15:8]), 32'd3);
    run(5, hi, tk);
    h1 += hi;
    check("upd_first_hi", 32'(h1), 32'd3);
    check("upd_duty_new", 32'(bus.status[15:8]), 32'd6);
    run(10, hi, tk);
    check("upd_next_hi", 32'(hi), 32'd6);

    // Disable mid-period with inv=1, then re-enable
    restart(mk(1, 1, 9, 0, 3));
    reach_cnt5();
    bus.ctrl_in = mk(0, 1, 9, 0, 3);
    cyc();
    check("dis_pwm", 32'(bus.pwm_out), 32'd1);
    check("dis_cnt", 32'(bus.status[7:0]), 32'd0);
    check("dis_tick", 32'(bus.period_tick), 32'd0);
    bus.ctrl_in = mk(1, 1, 9, 0, 3);
    run(10, hi, tk);
    check("reen_hi", 32'(hi), 32'd7);
    check("reen_tk", 32'(tk), 32'd1);

    // Asynchronous reset mid-period
    restart(mk(1, 0, 9, 0, 3));
    reach_cnt5();
    bus.ctrl_in = mk(0, 0, 9, 0, 3);
    pulse_reset();
    run(3, hi, tk);
    check("post_rst_tk", 32'(tk), 32'd0);

    // Minimum period
    restart(mk(1, 0, 0, 0, 1));
    run(20, hi, tk);
    check("min_hi", 32'(hi), 32'd20);
    check("min_tk", 32'(tk), 32'd20);

    // Random segments, including ignored upper bits and occasional disable/reset
    for (int s = 0; s < 150; s++) begin
      c = $urandom;
      c[7:0]   = 8'($urandom_range(0, 18));
      c[15:8]  = 8'($urandom_range(0, 3));
      c[23:16] = 8'($urandom_range(0, 15));
      c[24]    = ($urandom_range(0, 15) != 0);
      bus.ctrl_in = c;
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else run(int'($urandom_range(1, 60)), hi, tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
